pe_nic: RTL and testbench

Network interface controller between a processing element (PE) and the PE port of its mesh router. It holds one 64-bit injection (output channel) buffer and one 64-bit ejection (input channel) buffer. The PE sees them as four memory-mapped registers. The router sees the standard si/ri/so/ro/polarity link, so this block is the PE-side end of the router's local port.

---
 rtl/pe_nic_if.sv | 29 ++
 rtl/pe_nic.sv | 111 +++++++++++
 tb/tb_pe_nic.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_nic_if.sv
// PE register bus plus router local-port link for the NIC.
// The master side is the environment (PE + router); the slave side is the NIC itself.
interface pe_nic_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  nicEn;
  logic                  nicWrEn;
  logic                  net_so;
  logic                  net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  logic                  net_polarity;
  logic                  net_si;
  logic                  net_ri;
  logic [DATA_WIDTH-1:0] net_di;

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
    input  d_out, net_so, net_do, net_ri
  );

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
    output d_out, net_so, net_do, net_ri
  );
endinterface

// File: rtl/pe_nic.sv
// PE-side end of a mesh router local port: one injection and one ejection
// packet buffer, exposed to the PE as four memory-mapped registers.
module pe_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  pe_nic_if.slave bus
);

  typedef enum logic { OUT_EMPTY = 1'b0, OUT_FULL = 1'b1 } out_st_e;
  typedef enum logic { IN_EMPTY  = 1'b0, IN_FULL  = 1'b1 } in_st_e;

  localparam logic [ADDR_WIDTH-1:0] A_IN_BUF  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_IN_STS  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_BUF = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_STS = ADDR_WIDTH'(3);

  out_st_e               out_st_q, out_st_d;
  in_st_e                in_st_q,  in_st_d;
  logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
  logic [DATA_WIDTH-1:0] in_buf_q,  in_buf_d;
  logic [DATA_WIDTH-1:0] d_out_q,   d_out_d;

  logic pe_wr, pe_rd, wr_out, rd_in;
  logic so, ri, out_full, in_full;

  assign pe_wr  = bus.nicEn &  bus.nicWrEn;
  assign pe_rd  = bus.nicEn & ~bus.nicWrEn;
  assign wr_out = pe_wr & (bus.addr == A_OUT_BUF);
  assign rd_in  = pe_rd & (bus.addr == A_IN_BUF);

  assign out_full = (out_st_q == OUT_FULL);
  assign in_full  = (in_st_q  == IN_FULL);

  // A packet on VC v may only be offered in cycles where the router polarity equals v.
  assign so = out_full & (out_buf_q[DATA_WIDTH-1] == bus.net_polarity);
  assign ri = ~in_full;

  assign bus.net_so = so;
  assign bus.net_ri = ri;
  assign bus.net_do = out_buf_q;
  assign bus.d_out  = d_out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_st_q  <= OUT_EMPTY;
      in_st_q   <= IN_EMPTY;
      out_buf_q <= '0;
      in_buf_q  <= '0;
      d_out_q   <= '0;
    end else begin
      out_st_q  <= out_st_d;
      in_st_q   <= in_st_d;
      out_buf_q <= out_buf_d;
      in_buf_q  <= in_buf_d;
      d_out_q   <= d_out_d;
    end
  end

  // Injection: writes while full are dropped, including the edge the router drains us.
  always_comb begin
    out_st_d  = out_st_q;
    out_buf_d = out_buf_q;
    unique case (out_st_q)
      OUT_EMPTY: begin
        if (wr_out) begin
          out_st_d  = OUT_FULL;
          out_buf_d = bus.d_in;
        end
      end
      OUT_FULL: begin
        if (so && bus.net_ro) out_st_d = OUT_EMPTY;
      end
      default: out_st_d = OUT_EMPTY;
    endcase
  end

  always_comb begin
    in_st_d  = in_st_q;
    in_buf_d = in_buf_q;
    unique case (in_st_q)
      IN_EMPTY: begin
        if (bus.net_si && ri) begin
          in_st_d  = IN_FULL;
          in_buf_d = bus.net_di;
        end
      end
      IN_FULL: begin
        if (rd_in) in_st_d = IN_EMPTY;
      end
      default: in_st_d = IN_EMPTY;
    endcase
  end

  // Status reads reflect pre-edge state; in_buf is returned stale when empty.
  always_comb begin
    d_out_d = d_out_q;
    if (pe_rd) begin
      unique case (bus.addr)
        A_IN_BUF:  d_out_d = in_buf_q;
        A_IN_STS:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full};
        A_OUT_BUF: d_out_d = '0;
        A_OUT_STS: d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full};
        default:   d_out_d = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_nic.sv
// Self-checking bench for pe_nic: queue-based packet model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pe_nic;
  localparam int DW = 64;

  logic clk;
  logic rst_n;
  int   vectors    = 0;
  int   miscompares = 0;

  pe_nic_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) ifc ();

  pe_nic #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ifc.net_polarity = 1'b0;
    forever begin
      @(posedge clk);
      #1 ifc.net_polarity = ~ifc.net_polarity;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_out_q[$];
  logic [DW-1:0] m_in_q[$];
  logic [DW-1:0] m_do, m_in_last, m_dout;
  int            m_xfers = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit of, inf, so;
    if (!rst_n) begin
      m_out_q.delete();
      m_in_q.delete();
      m_do = '0; m_in_last = '0; m_dout = '0;
    end else begin
      of  = (m_out_q.size() != 0);
      inf = (m_in_q.size() != 0);
      so  = of ? (m_out_q[0][DW-1] == ifc.net_polarity) : 1'b0;
      if (ifc.nicEn && !ifc.nicWrEn) begin
        case (ifc.addr)
          2'd0: begin m_dout = m_in_last; if (inf) void'(m_in_q.pop_front()); end
          2'd1: m_dout = DW'(inf);
          2'd2: m_dout = '0;
          default: m_dout = DW'(of);
        endcase
      end
      if (so && ifc.net_ro) begin void'(m_out_q.pop_front()); m_xfers++; end
      if (ifc.nicEn && ifc.nicWrEn && ifc.addr == 2'd2 && !of) begin
        m_out_q.push_back(ifc.d_in);
        m_do = ifc.d_in;
      end
      if (ifc.net_si && !inf) begin
        m_in_q.push_back(ifc.net_di);
        m_in_last = ifc.net_di;
      end
    end
  end

  // ---------------- compare + transfer monitor ----------------
  logic [DW-1:0] sent[$];
  logic          sent_pol[$];
  int            dut_xfers = 0;

  always @(negedge clk) begin : compare
    logic exp_so;
    exp_so = (m_out_q.size() != 0) ? (m_out_q[0][DW-1] == ifc.net_polarity) : 1'b0;
    chk("net_so", DW'(ifc.net_so), DW'(exp_so));
    chk("net_ri", DW'(ifc.net_ri), DW'(m_in_q.size() == 0));
    chk("net_do", ifc.net_do, m_do);
    chk("d_out",  ifc.d_out,  m_dout);
    if (ifc.net_so && ifc.net_ro) begin
      sent.push_back(ifc.net_do);
      sent_pol.push_back(ifc.net_polarity);
      dut_xfers++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    ifc.nicEn = 1'b0; ifc.nicWrEn = 1'b0; ifc.net_si = 1'b0;
  endtask

  task automatic pe_write(input logic [1:0] a, input logic [DW-1:0] d);
    ifc.nicEn = 1'b1; ifc.nicWrEn = 1'b1; ifc.addr = a; ifc.d_in = d;
    tick();
    ifc.nicEn = 1'b0;
  endtask

  task automatic pe_read(input logic [1:0] a);
    ifc.nicEn = 1'b1; ifc.nicWrEn = 1'b0; ifc.addr = a;
    tick();
    ifc.nicEn = 1'b0;
  endtask

  task automatic vc_test(input logic [DW-1:0] pkt);
    sent.delete(); sent_pol.delete();
    ifc.net_ro = 1'b1;
    pe_write(2'd2, pkt);
    chk("vc_net_do", ifc.net_do, pkt);
    for (int i = 0; i < 4; i++) tick();
    chk("vc_count", DW'(sent.size()), DW'(1));
    if (sent.size() == 1) begin
      chk("vc_pkt", sent[0], pkt);
      chk("vc_pol", DW'(sent_pol[0]), DW'(pkt[DW-1]));
    end
    pe_read(2'd3);
    chk("vc_sts", ifc.d_out, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.addr = '0; ifc.d_in = '0; ifc.nicEn = 1'b0; ifc.nicWrEn = 1'b0;
    ifc.net_ro = 1'b0; ifc.net_si = 1'b0; ifc.net_di = '0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      tick();
      ifc.nicEn = 1'($urandom); ifc.nicWrEn = 1'($urandom); ifc.addr = 2'($urandom);
      ifc.d_in = {$urandom, $urandom}; ifc.net_si = 1'($urandom);
      ifc.net_di = {$urandom, $urandom}; ifc.net_ro = 1'($urandom);
    end
    chk("rst_so", DW'(ifc.net_so), '0);
    chk("rst_ri", DW'(ifc.net_ri), DW'(1));
    chk("rst_dout", ifc.d_out, '0);
    idle(); ifc.net_ro = 1'b0;
    tick();
    rst_n = 1'b1;
    pe_read(2'd1); chk("rst_in_sts", ifc.d_out, '0);
    pe_read(2'd3); chk("rst_out_sts", ifc.d_out, '0);

    // injection on both VCs
    vc_test(64'h8000_0000_0000_00AA);
    vc_test(64'h0000_0000_0000_0055);

    // backpressure and drop
    sent.delete();
    ifc.net_ro = 1'b0;
    pe_write(2'd2, 64'h1);
    pe_write(2'd2, 64'h2);
    chk("bp_net_do", ifc.net_do, 64'h1);
    pe_read(2'd3); chk("bp_sts", ifc.d_out, 64'h1);
    ifc.net_ro = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_count", DW'(sent.size()), DW'(1));
    if (sent.size() == 1) chk("bp_pkt", sent[0], 64'h1);

    // ejection
    ifc.net_si = 1'b1; ifc.net_di = 64'h0123_4567_89AB_CDEF;
    tick();
    ifc.net_si = 1'b0;
    chk("ej_ri_low", DW'(ifc.net_ri), '0);
    pe_read(2'd1); chk("ej_sts", ifc.d_out, 64'h1);
    ifc.net_si = 1'b1; ifc.net_di = 64'hDEAD_BEEF_0000_0000;
    tick();
    ifc.net_si = 1'b0;
    pe_read(2'd0);
    chk("ej_data", ifc.d_out, 64'h0123_4567_89AB_CDEF);
    chk("ej_ri_high", DW'(ifc.net_ri), DW'(1));
    pe_read(2'd1); chk("ej_sts_empty", ifc.d_out, '0);

    // write on the same edge the router drains the previous packet
    sent.delete();
    ifc.net_ro = 1'b0;
    pe_write(2'd2, 64'h0000_0000_0000_0A0A);
    for (int i = 0; i < 3 && !ifc.net_so; i++) tick();
    chk("sim_so_ready", DW'(ifc.net_so), DW'(1));
    ifc.net_ro = 1'b1;
    pe_write(2'd2, 64'h0000_0000_0000_0B0B);
    ifc.net_ro = 1'b0;
    pe_read(2'd3); chk("sim_sts", ifc.d_out, '0);
    chk("sim_net_do", ifc.net_do, 64'h0000_0000_0000_0A0A);
    chk("sim_count", DW'(sent.size()), DW'(1));

    // reset while both buffers are full
    ifc.net_ro = 1'b0;
    ifc.net_si = 1'b1; ifc.net_di = 64'h5555_AAAA_5555_AAAA;
    pe_write(2'd2, 64'h0000_0000_0000_0777);
    ifc.net_si = 1'b0;
    chk("mr_ri_full", DW'(ifc.net_ri), '0);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_so", DW'(ifc.net_so), '0);
    chk("mr_ri", DW'(ifc.net_ri), DW'(1));
    chk("mr_do", ifc.net_do, '0);
    tick();
    rst_n = 1'b1;
    pe_read(2'd1); chk("mr_in_sts", ifc.d_out, '0);
    pe_read(2'd3); chk("mr_out_sts", ifc.d_out, '0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ifc.nicEn   = ($urandom_range(0, 2) != 0);
      ifc.nicWrEn = 1'($urandom);
      ifc.addr    = 2'($urandom);
      ifc.d_in    = {$urandom, $urandom};
      ifc.net_si  = ($urandom_range(0, 2) == 0);
      ifc.net_di  = {$urandom, $urandom};
      ifc.net_ro  = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    idle();
    tick();
    chk("xfer_total", DW'(dut_xfers), DW'(m_xfers));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
